// File: rtl/sar_avg_pkg.sv
// sar_avg_pkg: shared state encoding and width helpers for the SAR result averager.
package sar_avg_pkg;
    typedef enum logic [2:0] {IDLE, HOLD, WAIT_EOC, CAPTURE, OUTPUT} state_t;
    localparam int TIMER_W = 16;
    function automatic int ACC_W(input int n_bits, input int log2_avg);
        return n_bits + log2_avg;
    endfunction
endpackage

// File: rtl/sar_eoc_edge_detect.sv
// sar_eoc_edge_detect: one-cycle pulse on each rising edge of the clk-synchronous eoc level.
module sar_eoc_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic eoc,
    output logic eoc_rise
);
    logic eoc_q;
    always_ff @(posedge clk) eoc_q <= reset ? 1'b0 : eoc;
    assign eoc_rise = eoc & ~eoc_q;
endmodule

// File: rtl/sar_result_averager.sv
// sar_result_averager: drives SAR hold, captures results on eoc rise, averages 2**LOG2_AVG per burst.
// Define SAR_AVG_MINMAX_EN to add per-burst avg_min_digital/avg_max_digital outputs.
module sar_result_averager
    import sar_avg_pkg::*;
#(
    parameter int N_BITS      = 10,
    parameter int LOG2_AVG    = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              input_hold_digital,
    input  logic              eoc,
    input  logic [N_BITS-1:0] adc_result_digital,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic [N_BITS-1:0] avg_result_digital,
    output logic              timeout_err
`ifdef SAR_AVG_MINMAX_EN
    ,
    output logic [N_BITS-1:0] avg_min_digital,
    output logic [N_BITS-1:0] avg_max_digital
`endif
);
    localparam int AW = ACC_W(N_BITS, LOG2_AVG);
    localparam int CW = LOG2_AVG + 1;
    state_t state, state_n;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [TIMER_W-1:0] timer;
    logic eoc_rise, capture_hit, timeout_hit, clear, full;
    sar_eoc_edge_detect u_edge (
        .clk(clk),
        .reset(reset),
        .eoc(eoc),
        .eoc_rise(eoc_rise)
    );
    assign capture_hit = (state == WAIT_EOC) && eoc_rise;
    assign timeout_hit = (state == WAIT_EOC) && !eoc_rise && (timer == TIMER_W'(TIMEOUT_CYC - 1));
    assign clear = ((state == OUTPUT) && avg_ready) || timeout_hit;
    assign full = cnt == CW'(2 ** LOG2_AVG);
    assign input_hold_digital = (state == HOLD) || (state == WAIT_EOC);
    assign avg_valid = state == OUTPUT;
    assign avg_result_digital = avg_valid ? N_BITS'(acc >> LOG2_AVG) : '0;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = enable ? HOLD : IDLE;
            HOLD:     state_n = WAIT_EOC;
            WAIT_EOC: state_n = eoc_rise ? CAPTURE : timeout_hit ? IDLE : WAIT_EOC;
            CAPTURE:  state_n = full ? OUTPUT : HOLD;
            OUTPUT:   state_n = !avg_ready ? OUTPUT : enable ? HOLD : IDLE;
            default:  state_n = IDLE;
        endcase
    end
    // The sample is folded into acc on the rise cycle itself; CAPTURE only decides where to go.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_n;
            timer <= (state == WAIT_EOC) ? timer + TIMER_W'(1) : '0;
            if (timeout_hit) timeout_err <= 1'b1;
            if (capture_hit) begin
                acc <= acc + AW'(adc_result_digital);
                cnt <= cnt + CW'(1);
            end else if (clear) begin
                acc <= '0;
                cnt <= '0;
            end
        end
    end
`ifdef SAR_AVG_MINMAX_EN
    logic [N_BITS-1:0] mn, mx;
    always_ff @(posedge clk) begin
        if (reset || (!capture_hit && clear)) begin
            mn <= '1;
            mx <= '0;
        end else if (capture_hit) begin
            if (adc_result_digital < mn) mn <= adc_result_digital;
            if (adc_result_digital > mx) mx <= adc_result_digital;
        end
    end
    assign avg_min_digital = avg_valid ? mn : '0;
    assign avg_max_digital = avg_valid ? mx : '0;
`endif
endmodule

// File: tb/tb_sar_result_averager.sv
// tb_sar_result_averager: directed bench with a behavioural SAR ADC responder on the hold/eoc pair.
module tb_sar_result_averager;
    logic clk = 1'b0, reset = 1'b1, enable = 1'b0, eoc = 1'b0, avg_ready = 1'b0;
    logic [9:0] adc_result_digital = '0;
    logic input_hold_digital, avg_valid, timeout_err;
    logic [9:0] avg_result_digital;
`ifdef SAR_AVG_MINMAX_EN
    logic [9:0] avg_min_digital, avg_max_digital;
`endif
    int tests = 0, fails = 0, hold_rises = 0, eoc_len = 1;
    logic hold_prev = 1'b0;
    int res_q[$];

    always #5 clk = ~clk;

    sar_result_averager dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .input_hold_digital(input_hold_digital),
        .eoc(eoc),
        .adc_result_digital(adc_result_digital),
        .avg_valid(avg_valid),
        .avg_ready(avg_ready),
        .avg_result_digital(avg_result_digital),
        .timeout_err(timeout_err)
`ifdef SAR_AVG_MINMAX_EN
        ,
        .avg_min_digital(avg_min_digital),
        .avg_max_digital(avg_max_digital)
`endif
    );

    always @(posedge clk) begin
        #2;
        if (input_hold_digital && !hold_prev) hold_rises++;
        hold_prev = input_hold_digital;
    end

    // ADC model: one cycle after seeing hold, present the next queued result with an eoc pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (input_hold_digital && res_q.size() > 0) begin
                @(negedge clk);
                adc_result_digital = 10'(res_q.pop_front());
                eoc = 1'b1;
                repeat (eoc_len) @(negedge clk);
                eoc = 1'b0;
            end
        end
    end

    task automatic start_burst(input int a, input int b, input int c, input int d);
        res_q.push_back(a);
        res_q.push_back(b);
        res_q.push_back(c);
        res_q.push_back(d);
        enable = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = avg_valid;
        end
    endtask

    task automatic accept();
        avg_ready = 1'b1;
        @(negedge clk);
        avg_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (input_hold_digital !== 1'b0) begin fails++; $display("FAIL reset_hold got=%b exp=0", input_hold_digital); end
        tests++; if (avg_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", avg_valid); end
        tests++; if (avg_result_digital !== 10'd0) begin fails++; $display("FAIL reset_result got=%0d exp=0", avg_result_digital); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout got=%b exp=0", timeout_err); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_average();
        bit ok;
        int h0 = hold_rises;
        start_burst(100, 101, 102, 103);
        wait_valid(200, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL avg_valid_wait got=%b exp=1", ok); end
        tests++; if (avg_result_digital !== 10'd101) begin fails++; $display("FAIL avg_basic got=%0d exp=101", avg_result_digital); end
        tests++; if (hold_rises - h0 !== 4) begin fails++; $display("FAIL avg_hold_pulses got=%0d exp=4", hold_rises - h0); end
`ifdef SAR_AVG_MINMAX_EN
        tests++; if (avg_min_digital !== 10'd100) begin fails++; $display("FAIL avg_min got=%0d exp=100", avg_min_digital); end
        tests++; if (avg_max_digital !== 10'd103) begin fails++; $display("FAIL avg_max got=%0d exp=103", avg_max_digital); end
`endif
        enable = 1'b0;
        accept();
        tests++; if (avg_valid !== 1'b0) begin fails++; $display("FAIL avg_one_handshake got=%b exp=0", avg_valid); end
        tests++; if (input_hold_digital !== 1'b0) begin fails++; $display("FAIL avg_idle_after got=%b exp=0", input_hold_digital); end
    endtask

    task automatic test_truncate();
        bit ok;
        start_burst(0, 1, 2, 2);
        wait_valid(200, ok);
        enable = 1'b0;
        tests++; if (avg_result_digital !== 10'd1) begin fails++; $display("FAIL truncate got=%0d exp=1", avg_result_digital); end
        accept();
    endtask

    task automatic test_full_scale();
        bit ok;
        start_burst(1023, 1023, 1023, 1023);
        wait_valid(200, ok);
        enable = 1'b0;
        tests++; if (avg_result_digital !== 10'd1023) begin fails++; $display("FAIL full_scale got=%0d exp=1023", avg_result_digital); end
        accept();
    endtask

    task automatic test_timeout();
        int k = 0;
        int highs = 0;
        enable = 1'b1;
        for (int i = 0; i < 10 && !input_hold_digital; i++) @(negedge clk);
        tests++; if (input_hold_digital !== 1'b1) begin fails++; $display("FAIL timeout_hold_start got=%b exp=1", input_hold_digital); end
        // one HOLD cycle, then 64 WAIT_EOC cycles before the flag shows
        while (!timeout_err && k < 200) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        tests++; if (k !== 65) begin fails++; $display("FAIL timeout_latency got=%0d exp=65", k); end
        tests++; if (input_hold_digital !== 1'b0) begin fails++; $display("FAIL timeout_drop_hold got=%b exp=0", input_hold_digital); end
        repeat (10) begin
            @(negedge clk);
            if (input_hold_digital) highs++;
        end
        tests++; if (highs !== 0) begin fails++; $display("FAIL timeout_no_restart got=%0d exp=0", highs); end
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        tests++; if (input_hold_digital !== 1'b1) begin fails++; $display("FAIL timeout_restart got=%b exp=1", input_hold_digital); end
        tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_sticky got=%b exp=1", timeout_err); end
        for (int i = 0; i < 100 && input_hold_digital; i++) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int bad = 0;
        int h1;
        start_burst(10, 20, 30, 40);
        wait_valid(200, ok);
        h1 = hold_rises;
        repeat (20) begin
            @(negedge clk);
            if (avg_valid !== 1'b1 || avg_result_digital !== 10'd25) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL stall_stable got=%0d bad cycles exp=0 (result=%0d exp=25)", bad, avg_result_digital); end
        tests++; if (hold_rises - h1 !== 0) begin fails++; $display("FAIL stall_no_hold got=%0d exp=0", hold_rises - h1); end
        res_q.push_back(1); res_q.push_back(1); res_q.push_back(1); res_q.push_back(1);
        accept();
        tests++; if (input_hold_digital !== 1'b1) begin fails++; $display("FAIL b2b_hold_next got=%b exp=1", input_hold_digital); end
        wait_valid(200, ok);
        enable = 1'b0;
        tests++; if (avg_result_digital !== 10'd1) begin fails++; $display("FAIL b2b_second got=%0d exp=1", avg_result_digital); end
        accept();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int h0 = hold_rises;
        start_burst(50, 60, 70, 80);
        for (int i = 0; i < 200 && hold_rises - h0 < 3; i++) @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        tests++; if (input_hold_digital !== 1'b0) begin fails++; $display("FAIL midreset_hold got=%b exp=0", input_hold_digital); end
        tests++; if (avg_valid !== 1'b0) begin fails++; $display("FAIL midreset_valid got=%b exp=0", avg_valid); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL midreset_timeout got=%b exp=0", timeout_err); end
        repeat (3) @(negedge clk);
        res_q.delete();
        reset = 1'b0;
        @(negedge clk);
        h0 = hold_rises;
        start_burst(4, 4, 4, 8);
        wait_valid(200, ok);
        enable = 1'b0;
        tests++; if (avg_result_digital !== 10'd5) begin fails++; $display("FAIL midreset_fresh got=%0d exp=5", avg_result_digital); end
        tests++; if (hold_rises - h0 !== 4) begin fails++; $display("FAIL midreset_pulses got=%0d exp=4", hold_rises - h0); end
        accept();
    endtask

    task automatic test_long_eoc();
        bit ok;
        int h0 = hold_rises;
        eoc_len = 5;
        start_burst(7, 3, 9, 5);
        wait_valid(400, ok);
        enable = 1'b0;
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL long_eoc_valid got=%b exp=1", ok); end
        tests++; if (avg_result_digital !== 10'd6) begin fails++; $display("FAIL long_eoc_avg got=%0d exp=6", avg_result_digital); end
        tests++; if (hold_rises - h0 !== 4) begin fails++; $display("FAIL long_eoc_pulses got=%0d exp=4", hold_rises - h0); end
`ifdef SAR_AVG_MINMAX_EN
        tests++; if (avg_min_digital !== 10'd3) begin fails++; $display("FAIL minmax_min got=%0d exp=3", avg_min_digital); end
        tests++; if (avg_max_digital !== 10'd9) begin fails++; $display("FAIL minmax_max got=%0d exp=9", avg_max_digital); end
`endif
        accept();
        eoc_len = 1;
    endtask

    initial begin
        test_reset();
        test_average();
        test_truncate();
        test_full_scale();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_long_eoc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
